// File: rtl/bist_session_scheduler.sv
// bist_session_scheduler
// Shares a single LFSR/MISR BIST engine among NREQ requesters. Request rising
// edges are latched as pending sessions and granted round-robin. The engine
// is started with a START level, and the session is compared against a
// per-requester golden signature. Each requester gets a completion pulse, a
// pass flag and a sticky timeout flag.
//
// Engine handshake: ENG_START is a level. The engine runs while it is high
// and reports the end of a session with a one-cycle ENG_FINISH pulse, with
// ENG_SIG valid in that same cycle. ENG_FINISH is only honoured in RUN.
// START is then held low for at least GAP+1 cycles, so the engine always
// sees a low level before the next rising edge.
module bist_session_scheduler #(
  parameter int NREQ        = 4,
  parameter int SIG_W       = 16,
  parameter int TIMEOUT_CYC = 2048,
  parameter int GAP         = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*SIG_W-1:0] GOLDEN,
  input  logic                  ENG_FINISH,
  input  logic [SIG_W-1:0]      ENG_SIG,
  output logic                  ENG_START,
  output logic [NREQ-1:0]       GRANT,
  output logic                  BUSY,
  output logic [NREQ-1:0]       DONE,
  output logic [NREQ-1:0]       PASS,
  output logic [NREQ-1:0]       ERR,
  output logic [1:0]            dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int GW = $clog2(GAP) + 1;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [IW-1:0] PTR_LAST = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t state, state_n;

  logic [NREQ-1:0]  pend, pend_n;
  logic [NREQ-1:0]  req_q;
  logic [IW-1:0]    rr_ptr, rr_n;
  logic [IW-1:0]    owner, owner_n;
  logic [TW-1:0]    cnt, cnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [SIG_W-1:0] sig_q, sig_n;

  logic             start_n;
  logic [NREQ-1:0]  grant_n;
  logic [NREQ-1:0]  done_n;
  logic [NREQ-1:0]  pass_n;
  logic [NREQ-1:0]  err_n;

  logic [IW-1:0]    pick;
  logic             pick_valid;
  int               idx;
  logic [SIG_W-1:0] golden_sel;

  assign dbg_state  = state;
  assign golden_sel = GOLDEN[owner*SIG_W +: SIG_W];

  // Round-robin search: first pending bit at or above rr_ptr, wrapping.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && pend[IW'(idx)]) begin
        pick_valid = 1'b1;
        pick       = IW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (pick_valid) state_n = S_RUN;
      S_RUN: begin
        if (ENG_FINISH)        state_n = S_CHECK;
        else if (cnt == TO_LAST) state_n = S_GAP;
      end
      S_CHECK: state_n = S_GAP;
      S_GAP:   if (gcnt == GAP_LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and session datapath.
  always_comb begin
    start_n = ENG_START;
    grant_n = GRANT;
    done_n  = '0;
    pass_n  = PASS;
    err_n   = ERR;
    owner_n = owner;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    sig_n   = sig_q;
    pend_n  = pend;
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          owner_n       = pick;
          grant_n       = NREQ'(1) << pick;
          rr_n          = (pick == PTR_LAST) ? '0 : pick + IW'(1);
          err_n[pick]   = 1'b0;
          cnt_n         = '0;
          start_n       = 1'b1;
          // The owner's request is consumed here, so a new rising edge
          // seen during its own session queues one further session.
          pend_n[pick]  = 1'b0;
        end
      end
      S_RUN: begin
        if (ENG_FINISH) begin
          sig_n = ENG_SIG;
        end else if (cnt == TO_LAST) begin
          done_n[owner] = 1'b1;
          pass_n[owner] = 1'b0;
          err_n[owner]  = 1'b1;
          start_n       = 1'b0;
          grant_n       = '0;
          gcnt_n        = '0;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      S_CHECK: begin
        done_n[owner] = 1'b1;
        pass_n[owner] = (sig_q == golden_sel);
        start_n       = 1'b0;
        grant_n       = '0;
        gcnt_n        = '0;
      end
      S_GAP: begin
        gcnt_n = gcnt + GW'(1);
      end
      default: ;
    endcase
    // New rising edges are applied last so they win over a same-edge clear.
    pend_n = pend_n | (REQ & ~req_q);
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ENG_START <= 1'b0;
      GRANT     <= '0;
      BUSY      <= 1'b0;
      DONE      <= '0;
      PASS      <= '0;
      ERR       <= '0;
      pend      <= '0;
      req_q     <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      sig_q     <= '0;
    end else begin
      ENG_START <= start_n;
      GRANT     <= grant_n;
      BUSY      <= (state_n != S_IDLE);
      DONE      <= done_n;
      PASS      <= pass_n;
      ERR       <= err_n;
      pend      <= pend_n;
      req_q     <= REQ;
      rr_ptr    <= rr_n;
      owner     <= owner_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      sig_q     <= sig_n;
    end
  end

endmodule
